// File: rtl/ahb_arb_pkg.sv
// ============================================================
// ahb_arb_pkg : shared AHB-Lite codes and helpers for ahb_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam int MIN_MASTERS = 2;
  localparam int MAX_MASTERS = 16;

  // Undefined-length INCR behaves like SINGLE: no beats are reserved.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE, HBURST_INCR:   return 4'd0;
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

  function automatic bit nb_masters_ok(input int n);
    return (n >= MIN_MASTERS) && (n <= MAX_MASTERS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_picker.sv
// ============================================================
// ahb_rr_picker : combinational round-robin requester selection
// Rev 1.0
// ============================================================
`default_nettype none

module ahb_rr_picker #(
  parameter int NB = 4,
  parameter int IW = 2
) (
  input  logic [NB-1:0] i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int unsigned w_j;

  // Scan from farthest to nearest so the nearest requester after i_last wins.
  always_comb begin
    o_idx   = i_last;
    o_valid = 1'b0;
    w_j     = 0;
    for (int k = NB; k >= 1; k--) begin
      w_j = (int'(i_last) + k) % NB;
      if (i_req[w_j]) begin
        o_idx   = IW'(w_j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================
// ahb_arbiter : round-robin AHB-Lite arbiter, burst/lock aware
// Rev 1.0
// ============================================================
`default_nettype none

module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NB_MASTERS     = 4,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32
) (
  input  logic                                 hclk_i,
  input  logic                                 hreset_i,
  input  logic [NB_MASTERS-1:0]                hbusreq_i,
  input  logic [NB_MASTERS-1:0]                hlock_i,
  input  logic [NB_MASTERS*AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [NB_MASTERS*2-1:0]              htrans_i,
  input  logic [NB_MASTERS-1:0]                hwrite_i,
  input  logic [NB_MASTERS*3-1:0]              hsize_i,
  input  logic [NB_MASTERS*3-1:0]              hburst_i,
  input  logic [NB_MASTERS*4-1:0]              hprot_i,
  input  logic [NB_MASTERS*AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                                 hready_i,
  input  logic                                 hresp_i,
  output logic [NB_MASTERS-1:0]                hgrant_o,
  output logic [$clog2(NB_MASTERS)-1:0]        hmaster_o,
  output logic [$clog2(NB_MASTERS)-1:0]        hmaster_data_o,
  output logic [AHB_ADDR_WIDTH-1:0]            haddr_o,
  output logic [1:0]                           htrans_o,
  output logic                                 hwrite_o,
  output logic [2:0]                           hsize_o,
  output logic [2:0]                           hburst_o,
  output logic [3:0]                           hprot_o,
  output logic                                 hmastlock_o,
  output logic [AHB_DATA_WIDTH-1:0]            hwdata_o
);

  localparam int MW = $clog2(NB_MASTERS);

  generate
    if (!nb_masters_ok(NB_MASTERS)) begin : g_bad_nb_masters
      $fatal(1, "ahb_arbiter: NB_MASTERS out of range");
    end
  endgenerate

  logic [MW-1:0]         r_own;
  logic [MW-1:0]         r_down;
  logic [3:0]            r_cnt;
  logic [NB_MASTERS-1:0] r_grant;

  logic                  w_own_req;
  logic                  w_own_lock;
  logic [1:0]            w_htrans;
  logic [3:0]            w_cnt_nxt;
  logic                  w_arb;
  logic [MW-1:0]         w_pick;
  logic                  w_pick_valid;

  assign w_own_req  = hbusreq_i[r_own];
  assign w_own_lock = hlock_i[r_own];
  // A parked owner that is not requesting must not leak its HTRANS onto the bus.
  assign w_htrans   = w_own_req ? htrans_i[int'(r_own)*2 +: 2] : HTRANS_IDLE;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!hready_i) begin
      if (hresp_i) begin
        w_cnt_nxt = 4'd0;
      end
    end else if (w_htrans == HTRANS_NONSEQ) begin
      w_cnt_nxt = burst_len_m1(hburst_o);
    end else if ((w_htrans == HTRANS_SEQ) && (r_cnt != 4'd0)) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end
  end

  assign w_arb = hready_i && !w_own_lock && (w_cnt_nxt == 4'd0);

  ahb_rr_picker #(
    .NB (NB_MASTERS),
    .IW (MW)
  ) u_picker (
    .i_req   (hbusreq_i),
    .i_last  (r_own),
    .o_idx   (w_pick),
    .o_valid (w_pick_valid)
  );

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      r_own   <= '0;
      r_down  <= '0;
      r_cnt   <= 4'd0;
      r_grant <= NB_MASTERS'(1);
    end else begin
      r_cnt <= w_cnt_nxt;
      if (hready_i) begin
        r_down <= r_own;
        if (w_arb && w_pick_valid) begin
          r_own   <= w_pick;
          r_grant <= NB_MASTERS'(1) << w_pick;
        end
      end
    end
  end

  assign hgrant_o       = r_grant;
  assign hmaster_o      = r_own;
  assign hmaster_data_o = r_down;
  assign htrans_o       = w_htrans;
  assign haddr_o        = haddr_i[int'(r_own)*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
  assign hwrite_o       = hwrite_i[r_own];
  assign hsize_o        = hsize_i[int'(r_own)*3 +: 3];
  assign hburst_o       = hburst_i[int'(r_own)*3 +: 3];
  assign hprot_o        = hprot_i[int'(r_own)*4 +: 4];
  assign hmastlock_o    = w_own_lock;
  assign hwdata_o       = hwdata_i[int'(r_down)*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
// ============================================================
// tb_ahb_arbiter : directed + random checks against a rule-level model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, lk, wr;
  logic [N*AW-1:0] addr;
  logic [N*2-1:0]  tr;
  logic [N*3-1:0]  sz, hb;
  logic [N*4-1:0]  pr;
  logic [N*DW-1:0] wd;
  logic          rdy, resp;

  logic [N-1:0]  hgrant_o;
  logic [1:0]    hmaster_o, hmaster_data_o;
  logic [AW-1:0] haddr_o;
  logic [1:0]    htrans_o;
  logic          hwrite_o;
  logic [2:0]    hsize_o, hburst_o;
  logic [3:0]    hprot_o;
  logic          hmastlock_o;
  logic [DW-1:0] hwdata_o;

  ahb_arbiter #(
    .NB_MASTERS     (N),
    .AHB_DATA_WIDTH (DW),
    .AHB_ADDR_WIDTH (AW)
  ) dut (
    .hclk_i         (clk),
    .hreset_i       (rst),
    .hbusreq_i      (req),
    .hlock_i        (lk),
    .haddr_i        (addr),
    .htrans_i       (tr),
    .hwrite_i       (wr),
    .hsize_i        (sz),
    .hburst_i       (hb),
    .hprot_i        (pr),
    .hwdata_i       (wd),
    .hready_i       (rdy),
    .hresp_i        (resp),
    .hgrant_o       (hgrant_o),
    .hmaster_o      (hmaster_o),
    .hmaster_data_o (hmaster_data_o),
    .haddr_o        (haddr_o),
    .htrans_o       (htrans_o),
    .hwrite_o       (hwrite_o),
    .hsize_o        (hsize_o),
    .hburst_o       (hburst_o),
    .hprot_o        (hprot_o),
    .hmastlock_o    (hmastlock_o),
    .hwdata_o       (hwdata_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: address owner, data owner, beats still owed in the burst.
  int m_own  = 0;
  int m_down = 0;
  int m_rem  = 0;

  function automatic int beats(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      3'b110, 3'b111: return 16;
      default:        return 1;
    endcase
  endfunction

  // Requester at the smallest circular distance after the current owner.
  function automatic int pick(input int own, input logic [N-1:0] r);
    int best, bestd, d;
    best  = own;
    bestd = N + 1;
    for (int m = 0; m < N; m++) begin
      if (r[m]) begin
        d = (m - own - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = m;
        end
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    int nrem;
    logic [1:0] t;
    if (rst) begin
      m_own = 0; m_down = 0; m_rem = 0;
      return;
    end
    t    = req[m_own] ? tr[m_own*2 +: 2] : 2'b00;
    nrem = m_rem;
    if (!rdy) begin
      if (resp) nrem = 0;
    end else if (t == 2'b10) begin
      nrem = beats(hb[m_own*3 +: 3]) - 1;
    end else if (t == 2'b11) begin
      nrem = (m_rem > 0) ? m_rem - 1 : 0;
    end
    if (rdy) begin
      m_down = m_own;
      if (!lk[m_own] && nrem == 0) m_own = pick(m_own, req);
    end
    m_rem = nrem;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    int o, d;
    logic [1:0] et;
    o  = m_own;
    d  = m_down;
    et = req[o] ? tr[o*2 +: 2] : 2'b00;
    chk("hgrant",       32'(hgrant_o),       32'(1) << o);
    chk("hmaster",      32'(hmaster_o),      32'(o));
    chk("hmaster_data", 32'(hmaster_data_o), 32'(d));
    chk("htrans",       32'(htrans_o),       32'(et));
    chk("haddr",        haddr_o,             addr[o*AW +: AW]);
    chk("hwrite",       32'(hwrite_o),       32'(wr[o]));
    chk("hsize",        32'(hsize_o),        32'(sz[o*3 +: 3]));
    chk("hburst",       32'(hburst_o),       32'(hb[o*3 +: 3]));
    chk("hprot",        32'(hprot_o),        32'(pr[o*4 +: 4]));
    chk("hmastlock",    32'(hmastlock_o),    32'(lk[o]));
    chk("hwdata",       hwdata_o,            wd[d*DW +: DW]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; resp = 1'b0;
    req = '0; lk = '0; tr = '0; hb = '0;
    wr   = N'($urandom);
    sz   = (N*3)'($urandom);
    pr   = (N*4)'($urandom);
    addr = {$urandom, $urandom, $urandom, $urandom};
    wd   = {$urandom, $urandom, $urandom, $urandom};
    tr[1:0] = 2'b10;

    // Reset with master 0 driving NONSEQ but not requesting.
    step(); step();
    chk("rst_grant",  32'(hgrant_o),       32'h1);
    chk("rst_master", 32'(hmaster_o),      32'h0);
    chk("rst_dmast",  32'(hmaster_data_o), 32'h0);
    chk("rst_trans",  32'(htrans_o),       32'h0);
    rst = 1'b0;

    // Simultaneous M1/M2 requests alternate strictly.
    tr = '0; req = 4'b0110;
    step(); chk("rr1", 32'(hmaster_o), 32'd1);
    step(); chk("rr2", 32'(hmaster_o), 32'd2);
    step(); chk("rr3", 32'(hmaster_o), 32'd1);
    step(); chk("rr4", 32'(hmaster_o), 32'd2);

    // INCR8 by M2 from 0x1000, M3 requesting from beat 2.
    req = 4'b0100;
    hb[8:6] = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      tr[5:4] = (k == 1) ? 2'b10 : 2'b11;
      addr[2*AW +: AW] = 32'h1000 + 32'(4 * (k - 1));
      if (k == 2) req[3] = 1'b1;
      #1;
      chk("burst_addr", haddr_o, 32'h1000 + 32'(4 * (k - 1)));
      step();
      chk("burst_owner", 32'(hmaster_o), (k == 8) ? 32'd3 : 32'd2);
    end
    chk("burst_dlast", 32'(hmaster_data_o), 32'd2);
    req[2] = 1'b0; tr[5:4] = 2'b00;
    step(); chk("burst_dnext", 32'(hmaster_data_o), 32'd3);

    // Locked SINGLEs by M1 while M0 waits.
    req = 4'b0010; lk = 4'b0010;
    step(); chk("lock_acq", 32'(hmaster_o), 32'd1);
    req = 4'b0011; hb[5:3] = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tr[3:2] = 2'b10;
      step();
      chk("lock_grant", 32'(hgrant_o),    32'b0010);
      chk("lock_mlk",   32'(hmastlock_o), 32'd1);
    end
    lk = '0; req = 4'b0001; tr[3:2] = 2'b00;
    step(); chk("lock_rel", 32'(hmaster_o), 32'd0);

    // ERROR during INCR4 releases the burst at the next ready edge.
    req = 4'b1001; hb[2:0] = 3'b011;
    tr[1:0] = 2'b10; addr[AW-1:0] = 32'h2000;
    step(); chk("err_start", 32'(hmaster_o), 32'd0);
    tr[1:0] = 2'b11; addr[AW-1:0] = 32'h2004; rdy = 1'b0; resp = 1'b1;
    step(); chk("err_hold", 32'(hmaster_o), 32'd0);
    tr[1:0] = 2'b00; rdy = 1'b1;
    step();
    chk("err_arb", 32'(hmaster_o),      32'd3);
    chk("err_dat", 32'(hmaster_data_o), 32'd0);
    resp = 1'b0;

    // HREADY low freezes ownership during a pending handover.
    req = 4'b0010; tr = '0; rdy = 1'b0;
    repeat (5) begin
      step();
      chk("wait_own", 32'(hmaster_o),      32'd3);
      chk("wait_dn",  32'(hmaster_data_o), 32'd0);
    end
    rdy = 1'b1;
    step();
    chk("ho_own", 32'(hmaster_o),      32'd1);
    chk("ho_dn",  32'(hmaster_data_o), 32'd3);
    step();
    chk("ho_dn2", 32'(hmaster_data_o), 32'd1);

    // Reset in the middle of an INCR16 drops the burst.
    hb[5:3] = 3'b111; tr[3:2] = 2'b10;
    step();
    tr[3:2] = 2'b11;
    step(); step();
    rst = 1'b1;
    step();
    chk("mrst_grant", 32'(hgrant_o),  32'h1);
    chk("mrst_own",   32'(hmaster_o), 32'd0);
    chk("mrst_trans", 32'(htrans_o),  32'd0);
    rst = 1'b0;
    step(); chk("mrst_rearb", 32'(hmaster_o), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req  = N'($urandom);
      lk   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      wr   = N'($urandom);
      tr   = (N*2)'($urandom);
      hb   = (N*3)'($urandom);
      sz   = (N*3)'($urandom);
      pr   = (N*4)'($urandom);
      addr = {$urandom, $urandom, $urandom, $urandom};
      wd   = {$urandom, $urandom, $urandom, $urandom};
      rdy  = ($urandom_range(0, 3) != 0);
      resp = !rdy && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
